// File: rtl/shift_add8_odd_pipe.sv
// Odd-part coefficient stage of the 8-point HEVC DCT/IDCT: 89/75/50/18 matrix (or its
// transpose) built from shift-adds, elastic two-stage valid/ready pipeline with rounding/limit.
module shift_add8_odd_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 19,
  parameter int SHIFT = 0,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    inv,
  input  logic signed [IN_W-1:0]  b0,
  input  logic signed [IN_W-1:0]  b1,
  input  logic signed [IN_W-1:0]  b2,
  input  logic signed [IN_W-1:0]  b3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y3,
  output logic signed [OUT_W-1:0] y5,
  output logic signed [OUT_W-1:0] y7
);

  // Product/sum width: the largest row has |coefficient| total 232 < 2^8, so IN_W+8 is exact.
  localparam int PW = IN_W + 8;
  localparam int RW = PW + 1;
  localparam int CW = (RW > OUT_W) ? RW : OUT_W;

  localparam logic signed [CW-1:0] RND =
    (SHIFT > 0) ? (CW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {C89, C75, C50, C18} coef_e;

  function automatic logic signed [PW-1:0] mul_const(input logic signed [IN_W-1:0] x,
                                                     input coef_e c);
    logic signed [PW-1:0] xe;
    xe = {{8{x[IN_W-1]}}, x};
    case (c)
      C89:     mul_const = (xe <<< 6) + (xe <<< 4) + (xe <<< 3) + xe;
      C75:     mul_const = (xe <<< 6) + (xe <<< 3) + (xe <<< 1) + xe;
      C50:     mul_const = (xe <<< 5) + (xe <<< 4) + (xe <<< 1);
      default: mul_const = (xe <<< 4) + (xe <<< 1);
    endcase
  endfunction

  // Rounds half toward +inf, then clamps (SAT!=0) or keeps the low OUT_W bits.
  function automatic logic signed [OUT_W-1:0] limit(input logic signed [PW-1:0] s);
    logic signed [CW-1:0] r;
    r = (CW'(s) + RND) >>> SHIFT;
    if (SAT != 0 && r > MAXV)      limit = MAXV[OUT_W-1:0];
    else if (SAT != 0 && r < MINV) limit = MINV[OUT_W-1:0];
    else                           limit = r[OUT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------------
  logic s1_valid;
  logic s2_load;
  logic s1_adv;
  logic in_fire;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // ---------------------------------------------------------------------------------
  // Stage 1: per-term products of every coefficient magnitude, plus the beat's mode
  // ---------------------------------------------------------------------------------
  logic signed [IN_W-1:0] b_in [4];
  logic signed [PW-1:0]   s1_p89 [4];
  logic signed [PW-1:0]   s1_p75 [4];
  logic signed [PW-1:0]   s1_p50 [4];
  logic signed [PW-1:0]   s1_p18 [4];
  logic                   s1_inv;

  assign b_in[0] = b0;
  assign b_in[1] = b1;
  assign b_in[2] = b2;
  assign b_in[3] = b3;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  // NOTE: the small S1 data arrays are reset too, so S1 data reads as 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s1_p89[i] <= '0;
        s1_p75[i] <= '0;
        s1_p50[i] <= '0;
        s1_p18[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_inv   <= inv;
        for (int i = 0; i < 4; i++) begin
          s1_p89[i] <= mul_const(b_in[i], C89);
          s1_p75[i] <= mul_const(b_in[i], C75);
          s1_p50[i] <= mul_const(b_in[i], C50);
          s1_p18[i] <= mul_const(b_in[i], C18);
        end
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------
  // Stage 2: signed row sums for M (forward) or M^T (inverse)
  // ---------------------------------------------------------------------------------
  logic signed [PW-1:0] sum [4];

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) sum[i] = '0;
    if (s1_inv) begin
      sum[0] = -s1_p18[0] + s1_p50[1] - s1_p75[2] + s1_p89[3];
      sum[1] = -s1_p50[0] + s1_p89[1] - s1_p18[2] - s1_p75[3];
      sum[2] = -s1_p75[0] + s1_p18[1] + s1_p89[2] + s1_p50[3];
      sum[3] = -s1_p89[0] - s1_p75[1] - s1_p50[2] - s1_p18[3];
    end else begin
      sum[0] = -s1_p18[0] - s1_p50[1] - s1_p75[2] - s1_p89[3];
      sum[1] =  s1_p50[0] + s1_p89[1] + s1_p18[2] - s1_p75[3];
      sum[2] = -s1_p75[0] - s1_p18[1] + s1_p89[2] - s1_p50[3];
      sum[3] =  s1_p89[0] - s1_p75[1] + s1_p50[2] - s1_p18[3];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      y1        <= '0;
      y3        <= '0;
      y5        <= '0;
      y7        <= '0;
    end else begin
      if (s2_load) out_valid <= s1_valid;
      if (s1_adv) begin
        y1 <= limit(sum[0]);
        y3 <= limit(sum[1]);
        y5 <= limit(sum[2]);
        y7 <= limit(sum[3]);
      end
    end
  end

endmodule
